sync_gray_ptr: RTL

SYNC_GRAY_PTR -- requirements
Module: sync_gray_ptr

---
 rtl/sync_pkg.sv | 27 ++
 rtl/gray2bin.sv | 28 ++
 rtl/sync_gray_ptr.sv | 125 ++++++++++++
 3 files changed

// File: rtl/sync_pkg.sv
// +----------------------------------------------------------------------------+
// | Package     : sync_pkg                                                     |
// | Description : Shared constants for the Gray pointer synchronizer family:   |
// |               legal synchronizer depth range and default counter width.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package sync_pkg;

  // Legal number of synchronizer flops; below 2 is not metastability-safe,
  // above 4 only adds latency.
  localparam int STAGES_MIN     = 2;
  localparam int STAGES_MAX     = 4;
  localparam int STAGES_DEFAULT = 2;

  // Default width of the illegal-step error counter.
  localparam int CNTW_DEFAULT   = 8;

  // True when a synchronizer depth lies inside the legal range.
  function automatic bit stages_legal(input int stages);
    return (stages >= STAGES_MIN) && (stages <= STAGES_MAX);
  endfunction

endpackage : sync_pkg

`default_nettype wire

// File: rtl/gray2bin.sv
// +----------------------------------------------------------------------------+
// | Module      : gray2bin                                                     |
// | Description : Purely combinational Gray-to-binary converter for an         |
// |               (ADDR+1)-bit FIFO pointer. Binary bit i is the XOR of Gray   |
// |               bits ADDR down to i.                                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module gray2bin #(
  parameter int ADDR = 3
) (
  input  logic [ADDR:0] i_gray,
  output logic [ADDR:0] o_bin
);

  // One XOR reduction per output bit keeps every bit independent, so no
  // bit-to-bit feedback appears in the netlist.
  genvar gi;
  generate
    for (gi = 0; gi <= ADDR; gi++) begin : g_bit
      assign o_bin[gi] = ^i_gray[ADDR:gi];
    end
  endgenerate

endmodule : gray2bin

`default_nettype wire

// File: rtl/sync_gray_ptr.sv
// +----------------------------------------------------------------------------+
// | Module      : sync_gray_ptr                                                |
// | Description : Multi-flop synchronizer for a Gray-coded FIFO pointer coming |
// |               from a foreign clock domain. Provides the synchronized Gray  |
// |               pointer, a registered binary copy, a change pulse and an     |
// |               optional illegal-step checker.                               |
// | Options     : define SYNC_GRAY_CHK_EN to build the Gray step checker       |
// |               (step_err pulse + saturating err_cnt). Without it, both      |
// |               outputs are tied to zero.                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module sync_gray_ptr
  import sync_pkg::*;
#(
  parameter int ADDR   = 3,
  parameter int STAGES = STAGES_DEFAULT,
  parameter int CNTW   = CNTW_DEFAULT
) (
  input  logic            rclk,
  input  logic            rrst,
  input  logic [ADDR:0]   wptr_gray,
  output logic [ADDR:0]   rq_ptr_gray,
  output logic [ADDR:0]   rq_ptr_bin,
  output logic            ptr_chg,
  output logic            step_err,
  output logic [CNTW-1:0] err_cnt
);

  localparam int W = ADDR + 1;

  // Elaboration-time guard on the synchronizer depth.
  generate
    if (!stages_legal(STAGES)) begin : g_bad_stages
      $error("sync_gray_ptr: STAGES=%0d outside legal range %0d..%0d",
             STAGES, STAGES_MIN, STAGES_MAX);
    end
  endgenerate

  logic [W-1:0] r_sync [STAGES];
  logic [W-1:0] r_prev_gray;
  logic [W-1:0] r_bin;
  logic         r_chg;

  logic [W-1:0] w_last;
  logic [W-1:0] w_bin;
  logic [W-1:0] w_diff;
  logic         w_changed;

  // Synchronizer chain: stage 0 is the only flop that samples the foreign bus.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      for (int i = 0; i < STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= wptr_gray;
      for (int i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_last    = r_sync[STAGES-1];
  assign w_diff    = w_last ^ r_prev_gray;
  assign w_changed = |w_diff;

  gray2bin #(
    .ADDR (ADDR)
  ) u_gray2bin (
    .i_gray (w_last),
    .o_bin  (w_bin)
  );

  // Previous-value copy, binary pointer and change pulse all update together
  // so ptr_chg marks exactly the cycle in which rq_ptr_bin moves.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_prev_gray <= '0;
      r_bin       <= '0;
      r_chg       <= 1'b0;
    end else begin
      r_prev_gray <= w_last;
      r_bin       <= w_bin;
      r_chg       <= w_changed;
    end
  end

  assign rq_ptr_gray = w_last;
  assign rq_ptr_bin  = r_bin;
  assign ptr_chg     = r_chg;

`ifdef SYNC_GRAY_CHK_EN
  logic            r_step_err;
  logic [CNTW-1:0] r_err_cnt;
  logic            w_multi_bit;

  // More than one bit differs exactly when clearing the lowest set bit of the
  // difference still leaves something behind.
  assign w_multi_bit = |(w_diff & (w_diff - W'(1)));

  // Step checker: pulse alongside ptr_chg and count without wrapping.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_step_err <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_step_err <= w_multi_bit;
      if (w_multi_bit && (r_err_cnt != {CNTW{1'b1}})) begin
        r_err_cnt <= r_err_cnt + CNTW'(1);
      end
    end
  end

  assign step_err = r_step_err;
  assign err_cnt  = r_err_cnt;
`else
  assign step_err = 1'b0;
  assign err_cnt  = '0;
`endif

endmodule : sync_gray_ptr

`default_nettype wire
